dsc_sn2bin: RTL and testbench

//  Receive end of the stochastic-stream interface: decodes a framed unary/stochastic

---
 rtl/dsc_sn2bin.sv | 155 +++++++++++++++
 tb/tb_dsc_sn2bin.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsc_sn2bin.sv
// Stochastic-stream receiver: counts ones over a framed bitstream and returns the
// count with frame-length check, saturation flag and ACCUM cycle count on valid/ready.
module dsc_sn2bin #(
   parameter int LEN_WIDTH = 18,
   parameter int OUT_WIDTH = 18,
   parameter int CYC_WIDTH = 21
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [LEN_WIDTH-1:0] frame_len,
   input  logic                 sn_in,
   input  logic                 sn_valid,
   input  logic                 sn_last,
   output logic [OUT_WIDTH-1:0] z,
   output logic                 z_valid,
   input  logic                 z_ready,
   output logic                 busy,
   output logic                 len_err,
   output logic                 sat_err,
   output logic [CYC_WIDTH-1:0] cycles
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [OUT_WIDTH-1:0] ONES_ONE = {{(OUT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CYC_WIDTH-1:0] CYC_ONE  = {{(CYC_WIDTH-1){1'b0}}, 1'b1};

   state_t               state_q,   state_d;
   logic [LEN_WIDTH-1:0] len_q,     len_d;
   logic [LEN_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
   logic [OUT_WIDTH-1:0] ones_q,    ones_d;
   logic [CYC_WIDTH-1:0] cyc_q,     cyc_d;
   logic                 len_err_q, len_err_d;
   logic                 sat_err_q, sat_err_d;
   logic                 z_valid_q, z_valid_d;
   logic                 busy_q,    busy_d;

   logic [LEN_WIDTH-1:0] bit_inc;
   logic                 len_hit;
   logic                 frame_end;

   assign bit_inc   = bit_cnt_q + LEN_ONE;
   assign len_hit   = (bit_inc == len_q);
   // Whichever comes first, sn_last or reaching the programmed length, closes the frame.
   assign frame_end = sn_valid && (sn_last || len_hit);

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      bit_cnt_d = bit_cnt_q;
      ones_d    = ones_q;
      cyc_d     = cyc_q;
      len_err_d = len_err_q;
      sat_err_d = sat_err_q;
      z_valid_d = z_valid_q;
      busy_d    = busy_q;

      case (state_q)
         IDLE: begin
            z_valid_d = 1'b0;
            busy_d    = 1'b0;
            if (start) begin
               len_d     = frame_len;
               bit_cnt_d = '0;
               ones_d    = '0;
               cyc_d     = '0;
               len_err_d = 1'b0;
               sat_err_d = 1'b0;
               busy_d    = 1'b1;
               // An empty frame has nothing to accumulate; present z=0 right away.
               if (frame_len == '0) begin
                  state_d   = HOLD;
                  z_valid_d = 1'b1;
               end else begin
                  state_d   = ACCUM;
               end
            end
         end

         ACCUM: begin
            busy_d = 1'b1;
            if (cyc_q == '1) sat_err_d = 1'b1;
            else             cyc_d     = cyc_q + CYC_ONE;

            if (sn_valid) begin
               bit_cnt_d = bit_inc;
               if (sn_in) begin
                  if (ones_q == '1) sat_err_d = 1'b1;
                  else              ones_d    = ones_q + ONES_ONE;
               end
            end

            if (frame_end) begin
               len_err_d = sn_last ^ len_hit;
               z_valid_d = 1'b1;
               state_d   = HOLD;
            end
         end

         HOLD: begin
            busy_d    = 1'b1;
            z_valid_d = 1'b1;
            if (z_ready) begin
               z_valid_d = 1'b0;
               busy_d    = 1'b0;
               state_d   = IDLE;
            end
         end

         default: begin
            state_d   = IDLE;
            z_valid_d = 1'b0;
            busy_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         len_q     <= '0;
         bit_cnt_q <= '0;
         ones_q    <= '0;
         cyc_q     <= '0;
         len_err_q <= 1'b0;
         sat_err_q <= 1'b0;
         z_valid_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         bit_cnt_q <= bit_cnt_d;
         ones_q    <= ones_d;
         cyc_q     <= cyc_d;
         len_err_q <= len_err_d;
         sat_err_q <= sat_err_d;
         z_valid_q <= z_valid_d;
         busy_q    <= busy_d;
      end
   end

   assign z       = ones_q;
   assign z_valid = z_valid_q;
   assign busy    = busy_q;
   assign len_err = len_err_q;
   assign sat_err = sat_err_q;
   assign cycles  = cyc_q;

endmodule

// File: tb/tb_dsc_sn2bin.sv
// Bench for dsc_sn2bin: directed and random frames against a per-frame counting model,
// run on a full-width instance and a 3-bit-output instance sharing the same stimulus.
module tb_dsc_sn2bin;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [17:0] frame_len = '0;
   logic        sn_in = 1'b0, sn_valid = 1'b0, sn_last = 1'b0, z_ready = 1'b0;

   logic [17:0] z;
   logic [2:0]  z3;
   logic        z_valid, busy, len_err, sat_err;
   logic        z_valid3, busy3, len_err3, sat_err3;
   logic [20:0] cycles, cycles3;

   int tests = 0;
   int fails = 0;

   // per-cycle stimulus after the start cycle
   bit sv[512], si[512], sl[512];
   int sn;

   // expected results
   int          e_end;
   logic [17:0] e_z18;
   logic [2:0]  e_z3;
   logic [20:0] e_cyc;
   logic        e_lerr, e_sat18, e_sat3;

   always #5 clk = ~clk;

   dsc_sn2bin #(.LEN_WIDTH(18), .OUT_WIDTH(18), .CYC_WIDTH(21)) u_dut (
      .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
      .sn_in(sn_in), .sn_valid(sn_valid), .sn_last(sn_last),
      .z(z), .z_valid(z_valid), .z_ready(z_ready), .busy(busy),
      .len_err(len_err), .sat_err(sat_err), .cycles(cycles));

   dsc_sn2bin #(.LEN_WIDTH(18), .OUT_WIDTH(3), .CYC_WIDTH(21)) u_dut3 (
      .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
      .sn_in(sn_in), .sn_valid(sn_valid), .sn_last(sn_last),
      .z(z3), .z_valid(z_valid3), .z_ready(z_ready), .busy(busy3),
      .len_err(len_err3), .sat_err(sat_err3), .cycles(cycles3));

   // Frame semantics: every cycle after start counts; valid bits count toward the
   // length and ones; the frame closes on the first valid bit that has sn_last or
   // reaches len; ones saturate at the output width.
   function automatic void model(input int len);
      int ones18, ones3, bits;
      ones18 = 0; ones3 = 0; bits = 0;
      e_cyc = '0; e_lerr = 1'b0; e_sat18 = 1'b0; e_sat3 = 1'b0; e_end = -1;
      if (len != 0) begin
         for (int k = 0; k < sn; k++) begin
            e_cyc = e_cyc + 21'd1;
            if (sv[k]) begin
               bits++;
               if (si[k]) begin
                  if (ones18 == 262143) e_sat18 = 1'b1; else ones18++;
                  if (ones3 == 7)       e_sat3  = 1'b1; else ones3++;
               end
               if (sl[k] || bits == len) begin
                  e_lerr = (sl[k] != (bits == len));
                  e_end  = k;
                  break;
               end
            end
         end
      end
      e_z18 = ones18[17:0];
      e_z3  = ones3[2:0];
   endfunction

   task automatic run_frame(input int len, input bit do_hs);
      bit done;
      bit early;
      done = 1'b0;
      early = 1'b0;
      model(len);
      if (len != 0 && e_end < 0) begin
         tests++; fails++;
         $display("FAIL model_no_end: stimulus never closes frame len=%0d", len);
      end
      @(negedge clk);
      start = 1'b1;
      frame_len = len[17:0];
      @(negedge clk);
      start = 1'b0;
      if (len != 0) begin
         tests++;
         if (busy !== 1'b1 || z_valid !== 1'b0) begin
            fails++;
            $display("FAIL accum_entry: busy=%b z_valid=%b, want busy=1 z_valid=0", busy, z_valid);
         end
         for (int k = 0; k < sn && !done; k++) begin
            sn_valid  = sv[k];
            sn_in     = si[k];
            sn_last   = sl[k];
            start     = 1'($urandom_range(0, 1));
            frame_len = 18'($urandom_range(0, 255));
            @(negedge clk);
            if (k == e_end) done = 1'b1;
            else if (z_valid !== 1'b0) early = 1'b1;
         end
         sn_valid = 1'b0; sn_in = 1'b0; sn_last = 1'b0; start = 1'b0;
         tests++;
         if (early) begin
            fails++;
            $display("FAIL z_valid_early: z_valid rose before final bit (len=%0d)", len);
         end
      end
      tests++;
      if (z_valid !== 1'b1 || z_valid3 !== 1'b1 || busy !== 1'b1) begin
         fails++;
         $display("FAIL z_valid_rise: z_valid=%b z_valid3=%b busy=%b, want 1 1 1", z_valid, z_valid3, busy);
      end
      tests++;
      if (z !== e_z18 || cycles !== e_cyc) begin
         fails++;
         $display("FAIL result: z=%0d cycles=%0d, want z=%0d cycles=%0d (len=%0d)", z, cycles, e_z18, e_cyc, len);
      end
      tests++;
      if (len_err !== e_lerr || sat_err !== e_sat18) begin
         fails++;
         $display("FAIL flags: len_err=%b sat_err=%b, want %b %b (len=%0d)", len_err, sat_err, e_lerr, e_sat18, len);
      end
      tests++;
      if (z3 !== e_z3 || sat_err3 !== e_sat3 || len_err3 !== e_lerr || cycles3 !== e_cyc) begin
         fails++;
         $display("FAIL narrow: z3=%0d sat3=%b lerr3=%b cyc3=%0d, want %0d %b %b %0d",
                  z3, sat_err3, len_err3, cycles3, e_z3, e_sat3, e_lerr, e_cyc);
      end
      if (do_hs) begin
         z_ready = 1'b1;
         @(negedge clk);
         z_ready = 1'b0;
         tests++;
         if (z_valid !== 1'b0 || busy !== 1'b0 || z !== e_z18) begin
            fails++;
            $display("FAIL handshake: z_valid=%b busy=%b z=%0d, want 0 0 %0d", z_valid, busy, z, e_z18);
         end
      end
   endtask

   task automatic load_bits(input int n, input logic [63:0] bits, input bit last_on_final);
      sn = n;
      for (int k = 0; k < n; k++) begin
         sv[k] = 1'b1;
         si[k] = bits[k];
         sl[k] = last_on_final && (k == n - 1);
      end
   endtask

   task automatic test_reset();
      #3;
      tests++;
      if (z !== '0 || z_valid !== 1'b0 || busy !== 1'b0 || len_err !== 1'b0 ||
          sat_err !== 1'b0 || cycles !== '0) begin
         fails++;
         $display("FAIL reset: z=%0d zv=%b busy=%b le=%b se=%b cyc=%0d, want all 0",
                  z, z_valid, busy, len_err, sat_err, cycles);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_basic();
      // bits 1,0,1,1,0,0,1,0 (LSB first)
      load_bits(8, 64'b01001101, 1'b1);
      run_frame(8, 1'b1);
   endtask

   task automatic test_alternate();
      sn = 128;
      for (int k = 0; k < 128; k++) begin
         sv[k] = (k % 2 == 0);
         si[k] = sv[k] ? 1'b1 : 1'($urandom_range(0, 1));
         sl[k] = (k == 126);
      end
      run_frame(64, 1'b1);
   endtask

   task automatic test_hold();
      load_bits(8, 64'b01001101, 1'b1);
      run_frame(8, 1'b0);
      for (int c = 0; c < 5; c++) begin
         z_ready  = 1'b0;
         start    = (c == 2);
         sn_valid = c[0];
         sn_in    = ~c[0];
         sn_last  = c[0];
         @(negedge clk);
         tests++;
         if (z_valid !== 1'b1 || z !== 18'd4) begin
            fails++;
            $display("FAIL hold_stable: cycle %0d z_valid=%b z=%0d, want 1 4", c, z_valid, z);
         end
      end
      sn_valid = 1'b0; sn_in = 1'b0; sn_last = 1'b0;
      start   = 1'b1;
      z_ready = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      z_ready = 1'b0;
      tests++;
      if (z_valid !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL hold_release: z_valid=%b busy=%b, want 0 0", z_valid, busy);
      end
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || z !== 18'd4) begin
         fails++;
         $display("FAIL start_in_handshake: busy=%b z=%0d, want 0 4", busy, z);
      end
   endtask

   task automatic test_len_err();
      load_bits(3, 64'b011, 1'b1);
      run_frame(8, 1'b1);
      load_bits(10, 64'b1111111111, 1'b0);
      run_frame(8, 1'b1);
   endtask

   task automatic test_boundary();
      sn = 0;
      run_frame(0, 1'b1);
      load_bits(12, 64'hFFF, 1'b1);
      run_frame(12, 1'b1);
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      start = 1'b1;
      frame_len = 18'd8;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         sn_valid = 1'b1; sn_in = 1'b1;
         @(negedge clk);
      end
      #2 rst = 1'b0;
      #1;
      tests++;
      if (z !== '0 || z_valid !== 1'b0 || busy !== 1'b0 || cycles !== '0 ||
          len_err !== 1'b0 || sat_err !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset: z=%0d zv=%b busy=%b cyc=%0d, want all 0", z, z_valid, busy, cycles);
      end
      sn_valid = 1'b0; sn_in = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      load_bits(4, 64'hF, 1'b1);
      run_frame(4, 1'b1);
   endtask

   task automatic test_random();
      int len;
      for (int f = 0; f < 25; f++) begin
         len = $urandom_range(1, 40);
         sn = 400;
         for (int k = 0; k < sn; k++) begin
            sv[k] = ($urandom_range(0, 3) != 0);
            si[k] = 1'($urandom_range(0, 1));
            sl[k] = ($urandom_range(0, 24) == 0);
         end
         sv[sn-1] = 1'b1;
         sl[sn-1] = 1'b1;
         run_frame(len, 1'b1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_alternate();
      test_hold();
      test_len_err();
      test_boundary();
      test_mid_reset();
      test_random();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
